// File: rtl/mir_executor.sv
// Microinstruction executor: holds one 33-bit microword, drives datapath selects,
// runs an optional memory handshake with timeout, then retires and sequences pc.
module mir_executor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [32:0] mir,
    input  logic        mir_valid,
    input  logic [11:0] br_addr,
    output logic        mir_ready,
    output logic [3:0]  alu_op,
    output logic [1:0]  sh_op,
    output logic        kmx,
    output logic [4:0]  a_sel,
    output logic [5:0]  b_sel,
    output logic [5:0]  c_sel,
    output logic        c_we,
    input  logic        alu_z,
    input  logic        alu_cy,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_ack,
    output logic [11:0] pc,
    output logic        flag_z,
    output logic        flag_cy,
    output logic        done,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, RETIRE} state_t;

    state_t      state_q, state_d;
    logic [32:0] hold_q, hold_d;
    logic [3:0]  wait_q, wait_d;
    logic [11:0] pc_q, pc_d;
    logic        flag_z_q, flag_z_d;
    logic        flag_cy_q, flag_cy_d;
    logic        mem_err_q, mem_err_d;

    logic        f_mr, f_mw, f_fen;
    logic [5:0]  f_cbus;
    logic [1:0]  f_cond;
    logic        br_taken;
    logic        bus_en;
    logic        unused_ttype;

    // Ttype bits are numbered by their position in mir, not within the field.
    assign f_mr         = hold_q[25];
    assign f_mw         = hold_q[24];
    assign f_cbus       = hold_q[17:12];
    assign f_fen        = hold_q[8];
    assign f_cond       = hold_q[6:5];
    assign unused_ttype = ^{hold_q[11:9], hold_q[7]};

    assign pc      = pc_q;
    assign flag_z  = flag_z_q;
    assign flag_cy = flag_cy_q;
    assign mem_err = mem_err_q;

    always_comb begin
        br_taken = 1'b0;
        case (f_cond)
            2'b01:   br_taken = flag_z_q;
            2'b10:   br_taken = ~flag_z_q;
            2'b11:   br_taken = flag_cy_q;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        wait_d    = wait_q;
        pc_d      = pc_q;
        flag_z_d  = flag_z_q;
        flag_cy_d = flag_cy_q;
        mem_err_d = mem_err_q;
        mir_ready = 1'b0;
        bus_en    = 1'b0;
        c_we      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        alu_op    = '0;
        sh_op     = '0;
        kmx       = 1'b0;
        a_sel     = '0;
        b_sel     = '0;
        c_sel     = '0;

        case (state_q)
            IDLE: begin
                mir_ready = rst_n;
                if (mir_valid) begin
                    hold_d  = mir;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                bus_en = 1'b1;
                c_we   = (f_cbus != 6'd0) && !f_mr;
                if (f_fen) begin
                    flag_z_d  = alu_z;
                    flag_cy_d = alu_cy;
                end
                wait_d  = '0;
                state_d = (f_mr || f_mw) ? MEM : RETIRE;
            end
            MEM: begin
                bus_en = 1'b1;
                mem_rd = f_mr;
                mem_wr = f_mw && !f_mr;
                // Fifteen ack-less cycles: the counter reaches 15 on the edge that leaves MEM.
                if (mem_ack) begin
                    c_we    = f_mr && (f_cbus != 6'd0);
                    state_d = RETIRE;
                end else if (wait_q == 4'd14) begin
                    wait_d    = 4'd15;
                    mem_err_d = 1'b1;
                    state_d   = RETIRE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RETIRE: begin
                done    = 1'b1;
                pc_d    = br_taken ? br_addr : pc_q + 12'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus_en) begin
            alu_op = hold_q[32:29];
            sh_op  = hold_q[28:27];
            kmx    = hold_q[26];
            a_sel  = hold_q[4:0];
            b_sel  = hold_q[23:18];
            c_sel  = hold_q[17:12];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            wait_q    <= '0;
            pc_q      <= '0;
            flag_z_q  <= 1'b0;
            flag_cy_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            pc_q      <= pc_d;
            flag_z_q  <= flag_z_d;
            flag_cy_q <= flag_cy_d;
            mem_err_q <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_mir_executor.sv
// Self-checking bench for mir_executor: directed scenarios plus randomized
// microwords checked against a field-level reference model.
module tb_mir_executor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [32:0] mir = '0;
    logic        mir_valid = 1'b0;
    logic [11:0] br_addr = '0;
    logic        alu_z = 1'b0;
    logic        alu_cy = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mir_ready, kmx, c_we, mem_rd, mem_wr, flag_z, flag_cy, done, mem_err;
    logic [3:0]  alu_op;
    logic [1:0]  sh_op;
    logic [4:0]  a_sel;
    logic [5:0]  b_sel, c_sel;
    logic [11:0] pc;
    logic [26:0] ctrl;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] ref_pc;
    logic        ref_z, ref_cy, ref_err;

    mir_executor dut (
        .clk(clk), .rst_n(rst_n), .mir(mir), .mir_valid(mir_valid), .br_addr(br_addr),
        .mir_ready(mir_ready), .alu_op(alu_op), .sh_op(sh_op), .kmx(kmx),
        .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel), .c_we(c_we),
        .alu_z(alu_z), .alu_cy(alu_cy), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .pc(pc), .flag_z(flag_z), .flag_cy(flag_cy),
        .done(done), .mem_err(mem_err)
    );

    assign ctrl = {alu_op, sh_op, kmx, a_sel, b_sel, c_sel, c_we, mem_rd, mem_wr};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [6:0] tt(input logic fen, input logic [1:0] cond);
        return {3'b000, fen, 1'b0, cond};
    endfunction

    function automatic logic [32:0] mk(input logic [3:0] alu, input logic [1:0] sh, input logic k,
                                       input logic mr, input logic mw, input logic [5:0] b,
                                       input logic [5:0] c, input logic [6:0] t, input logic [4:0] a);
        return {alu, sh, k, mr, mw, b, c, t, a};
    endfunction

    // Expected datapath outputs for a held word with the given strobe/request values.
    function automatic logic [26:0] exp_ctrl(input logic [32:0] w, input logic we,
                                             input logic rd, input logic wr);
        return {w[32:29], w[28:27], w[26], w[4:0], w[23:18], w[17:12], we, rd, wr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [32:0] w, input logic [11:0] br);
        mir = w; mir_valid = 1'b1; br_addr = br;
        step();
        mir_valid = 1'b0; mir = '0;
    endtask

    task automatic run_plain(input logic [32:0] w, input logic [11:0] br, input logic az, input logic acy);
        issue(w, br);
        alu_z = az; alu_cy = acy;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mir_valid = 1'b1; mem_ack = 1'b1; mir = '1;
        step(); step();
        @(negedge clk);
        n_cmp++; if (mir_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", mir_ready); end
        n_cmp++; if (ctrl !== 27'd0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", ctrl); end
        n_cmp++; if ({done, pc, flag_z, flag_cy, mem_err} !== 16'd0) begin
            n_err++; $display("FAIL reset_state: done=%b pc=%h z=%b cy=%b err=%b expected all 0", done, pc, flag_z, flag_cy, mem_err);
        end
        step();
        rst_n = 1'b1; mir_valid = 1'b0; mem_ack = 1'b0; mir = '0;
        @(negedge clk);
        n_cmp++; if (mir_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", mir_ready); end
        step();
        ref_pc = '0; ref_z = 1'b0; ref_cy = 1'b0; ref_err = 1'b0;
    endtask

    task automatic test_mok();
        mir = mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h11, 7'h00, 5'h00);
        mir_valid = 1'b1; br_addr = 12'h0;
        @(negedge clk);
        n_cmp++; if (mir_ready !== 1'b1) begin n_err++; $display("FAIL mok_ready: got %b expected 1", mir_ready); end
        step();
        mir_valid = 1'b0; mir = '1;
        @(negedge clk);
        n_cmp++; if ({c_we, c_sel, mir_ready, done} !== {1'b1, 6'h11, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL mok_exec: c_we=%b c_sel=%h ready=%b done=%b expected 1 11 0 0", c_we, c_sel, mir_ready, done);
        end
        step();
        @(negedge clk);
        n_cmp++; if ({done, c_we, pc} !== {1'b1, 1'b0, 12'h000}) begin
            n_err++; $display("FAIL mok_retire: done=%b c_we=%b pc=%h expected 1 0 000", done, c_we, pc);
        end
        step();
        @(negedge clk);
        n_cmp++; if ({pc, done, mir_ready} !== {12'h001, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL mok_after: pc=%h done=%b ready=%b expected 001 0 1", pc, done, mir_ready);
        end
        ref_pc = 12'h001;
    endtask

    task automatic test_mem_read();
        int rd_cnt = 0;
        logic cwe_ok = 1'b1;
        issue(mk(4'h3, 2'b01, 1'b1, 1'b1, 1'b0, 6'h0A, 6'h05, 7'h00, 5'h07), 12'h000);
        mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if ({c_we, mem_rd} !== 2'b00) begin n_err++; $display("FAIL memrd_exec: c_we=%b mem_rd=%b expected 0 0", c_we, mem_rd); end
        step();
        for (int k = 1; k <= 3; k++) begin
            mem_ack = (k == 3);
            @(negedge clk);
            if (mem_rd) rd_cnt++;
            if (c_we !== (k == 3)) cwe_ok = 1'b0;
            step();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (cwe_ok !== 1'b1) begin n_err++; $display("FAIL memrd_cwe: strobe pattern wrong, got ok=%b expected 1", cwe_ok); end
        n_cmp++; if ({done, mem_rd, c_we} !== 3'b100) begin
            n_err++; $display("FAIL memrd_retire: done=%b mem_rd=%b c_we=%b expected 1 0 0", done, mem_rd, c_we);
        end
        n_cmp++; if (rd_cnt != 3) begin n_err++; $display("FAIL memrd_cycles: got %0d expected 3", rd_cnt); end
        step();
        @(negedge clk);
        n_cmp++; if (pc !== 12'h002) begin n_err++; $display("FAIL memrd_pc: got %h expected 002", pc); end
        ref_pc = 12'h002;
    endtask

    task automatic test_branch();
        logic [32:0] w;
        w = mk(4'h1, 2'b00, 1'b0, 1'b0, 1'b0, 6'h01, 6'h00, tt(1'b1, 2'b01), 5'h02);
        issue(w, 12'h3A5);
        alu_z = 1'b1; alu_cy = 1'b0;
        step();
        alu_z = 1'b0;
        @(negedge clk);
        n_cmp++; if ({done, flag_z} !== 2'b11) begin n_err++; $display("FAIL branch_flag: done=%b flag_z=%b expected 1 1", done, flag_z); end
        step();
        @(negedge clk);
        n_cmp++; if (pc !== 12'h3A5) begin n_err++; $display("FAIL branch_taken_pc: got %h expected 3a5", pc); end
        run_plain(w, 12'h3A5, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({flag_z, pc} !== {1'b0, 12'h3A6}) begin
            n_err++; $display("FAIL branch_not_taken: flag_z=%b pc=%h expected 0 3a6", flag_z, pc);
        end
        ref_pc = 12'h3A6; ref_z = 1'b0; ref_cy = 1'b0;
    endtask

    task automatic test_timeout();
        int   wr_cnt = 0;
        logic cwe_seen = 1'b0;
        logic seen_done = 1'b0;
        issue(mk(4'h2, 2'b10, 1'b0, 1'b0, 1'b1, 6'h03, 6'h09, 7'h00, 5'h04), 12'h000);
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if ({c_we, mem_wr} !== 2'b10) begin n_err++; $display("FAIL timeout_exec: c_we=%b mem_wr=%b expected 1 0", c_we, mem_wr); end
        step();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin seen_done = 1'b1; break; end
            if (mem_wr) wr_cnt++;
            if (c_we) cwe_seen = 1'b1;
            step();
        end
        n_cmp++; if (seen_done !== 1'b1) begin n_err++; $display("FAIL timeout_done: got %b expected 1 within 20 cycles", seen_done); end
        n_cmp++; if (wr_cnt != 15) begin n_err++; $display("FAIL timeout_wr_cycles: got %0d expected 15", wr_cnt); end
        n_cmp++; if ({cwe_seen, c_we, mem_wr, mem_err} !== 4'b0001) begin
            n_err++; $display("FAIL timeout_state: cwe_seen=%b c_we=%b mem_wr=%b mem_err=%b expected 0 0 0 1", cwe_seen, c_we, mem_wr, mem_err);
        end
        step();
        @(negedge clk);
        n_cmp++; if (pc !== 12'h3A7) begin n_err++; $display("FAIL timeout_pc: got %h expected 3a7", pc); end
        run_plain(mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 7'h00, 5'h00), 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if ({mem_err, pc} !== {1'b1, 12'h3A8}) begin
            n_err++; $display("FAIL timeout_sticky: mem_err=%b pc=%h expected 1 3a8", mem_err, pc);
        end
    endtask

    task automatic test_reset_mid();
        logic done_seen = 1'b0;
        issue(mk(4'h5, 2'b00, 1'b0, 1'b1, 1'b0, 6'h02, 6'h07, 7'h00, 5'h01), 12'h000);
        mem_ack = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b1) begin n_err++; $display("FAIL rstmid_rd_before: got %b expected 1", mem_rd); end
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        if (done) done_seen = 1'b1;
        n_cmp++; if ({mem_rd, done_seen, mir_ready} !== 3'b000) begin
            n_err++; $display("FAIL rstmid_outputs: mem_rd=%b done=%b ready=%b expected 0 0 0", mem_rd, done_seen, mir_ready);
        end
        n_cmp++; if ({pc, mem_err, ctrl} !== 40'd0) begin
            n_err++; $display("FAIL rstmid_state: pc=%h mem_err=%b ctrl=%h expected 0 0 0", pc, mem_err, ctrl);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({mir_ready, done} !== 2'b10) begin n_err++; $display("FAIL rstmid_idle: ready=%b done=%b expected 1 0", mir_ready, done); end
        step();
        ref_pc = '0; ref_z = 1'b0; ref_cy = 1'b0; ref_err = 1'b0;
    endtask

    task automatic test_wrap();
        run_plain(mk(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, tt(1'b1, 2'b01), 5'h00), 12'hFFF, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (pc !== 12'hFFF) begin n_err++; $display("FAIL wrap_setup: got %h expected fff", pc); end
        run_plain(mk(4'h7, 2'b11, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, 7'h00, 5'h1F), 12'hABC, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL wrap_pc: got %h expected 000", pc); end
        ref_pc = 12'h000; ref_z = 1'b1; ref_cy = 1'b0; ref_err = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] r;
        logic [32:0] w;
        logic [11:0] br;
        logic        az, acy, mr, mw, fen, ack, taken;
        logic [1:0]  cond;
        int          ack_at;
        for (int n = 0; n < 60; n++) begin
            r = {$urandom, $urandom};
            w = r[32:0];
            br = 12'($urandom);
            az = 1'($urandom); acy = 1'($urandom);
            ack_at = $urandom_range(1, 18);
            mr = w[25]; mw = w[24]; fen = w[8]; cond = w[6:5];

            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                mir_valid = 1'b0; mir = w; mem_ack = 1'($urandom);
                @(negedge clk);
                n_cmp++; if ({mir_ready, done, ctrl} !== {2'b10, 27'd0}) begin
                    n_err++; $display("FAIL rnd_idle[%0d]: ready=%b done=%b ctrl=%h expected 1 0 0", n, mir_ready, done, ctrl);
                end
                step();
            end

            mir = w; mir_valid = 1'b1; mem_ack = 1'($urandom); br_addr = 12'($urandom);
            @(negedge clk);
            n_cmp++; if ({mir_ready, ctrl, pc} !== {1'b1, 27'd0, ref_pc}) begin
                n_err++; $display("FAIL rnd_accept[%0d]: ready=%b ctrl=%h pc=%h expected 1 0 %h", n, mir_ready, ctrl, pc, ref_pc);
            end
            step();

            r = {$urandom, $urandom};
            mir = r[32:0]; mir_valid = 1'($urandom); mem_ack = 1'($urandom);
            alu_z = az; alu_cy = acy; br_addr = 12'($urandom);
            @(negedge clk);
            n_cmp++; if ({mir_ready, done, ctrl} !== {2'b00, exp_ctrl(w, (w[17:12] != 6'd0) && !mr, 1'b0, 1'b0)}) begin
                n_err++; $display("FAIL rnd_exec[%0d]: ready=%b done=%b ctrl=%h expected 0 0 %h", n, mir_ready, done, ctrl,
                                  exp_ctrl(w, (w[17:12] != 6'd0) && !mr, 1'b0, 1'b0));
            end
            if (fen) begin ref_z = az; ref_cy = acy; end
            step();

            if (mr || mw) begin
                for (int k = 1; k <= 15; k++) begin
                    ack = (k == ack_at);
                    mem_ack = ack; alu_z = 1'($urandom); alu_cy = 1'($urandom);
                    mir_valid = 1'($urandom); br_addr = 12'($urandom);
                    @(negedge clk);
                    n_cmp++; if ({done, ctrl} !== {1'b0, exp_ctrl(w, ack && mr && (w[17:12] != 6'd0), mr, mw && !mr)}) begin
                        n_err++; $display("FAIL rnd_mem[%0d.%0d]: done=%b ctrl=%h expected 0 %h", n, k, done, ctrl,
                                          exp_ctrl(w, ack && mr && (w[17:12] != 6'd0), mr, mw && !mr));
                    end
                    step();
                    if (ack) break;
                    if (k == 15) ref_err = 1'b1;
                end
            end

            mem_ack = 1'($urandom); mir_valid = 1'($urandom); br_addr = br;
            alu_z = 1'($urandom); alu_cy = 1'($urandom);
            @(negedge clk);
            n_cmp++; if ({done, mir_ready, ctrl} !== {2'b10, 27'd0}) begin
                n_err++; $display("FAIL rnd_retire[%0d]: done=%b ready=%b ctrl=%h expected 1 0 0", n, done, mir_ready, ctrl);
            end
            n_cmp++; if ({flag_z, flag_cy, mem_err} !== {ref_z, ref_cy, ref_err}) begin
                n_err++; $display("FAIL rnd_flags[%0d]: z=%b cy=%b err=%b expected %b %b %b", n, flag_z, flag_cy, mem_err, ref_z, ref_cy, ref_err);
            end
            case (cond)
                2'b00:   taken = 1'b0;
                2'b01:   taken = ref_z;
                2'b10:   taken = !ref_z;
                default: taken = ref_cy;
            endcase
            ref_pc = taken ? br : 12'((int'(ref_pc) + 1) % 4096);
            step();
            mir_valid = 1'b0; mem_ack = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (pc !== ref_pc) begin n_err++; $display("FAIL rnd_final_pc: got %h expected %h", pc, ref_pc); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_mok();
        test_mem_read();
        test_branch();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mir_executor.md
MIR_EXECUTOR -- requirements
Module: mir_executor

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 SHALL expose the following ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  synchronous active-low reset
  mir  in  33  microinstruction word
  mir_valid  in  1  mir is valid this cycle
  br_addr  in  12  branch target, taken from IR[11:0]
  mir_ready  out  1  executor can accept a microinstruction
  alu_op  out  4  ALU function
  sh_op  out  2  shifter function
  kmx  out  1  constant mux select
  a_sel  out  5  A-bus source
  b_sel  out  6  B-bus source
  c_sel  out  6  C-bus destination
  c_we  out  1  register-file write strobe
  alu_z  in  1  ALU zero result
  alu_cy  in  1  ALU carry result
  mem_rd  out  1  memory read request
  mem_wr  out  1  memory write request
  mem_ack  in  1  memory access complete
  pc  out  12  program counter
  flag_z  out  1  registered zero flag
  flag_cy  out  1  registered carry flag
  done  out  1  one-cycle pulse at microinstruction retire
  mem_err  out  1  sticky memory-timeout error
REQ-003 SHALL split mir into these fields:
  ALU = [32:29], SH = [28:27], KMx = [26], MR = [25], MW = [24]
  Bbus = [23:18], Cbus = [17:12], Ttype = [11:5], Abus = [4:0]
REQ-004 SHALL decode Ttype as follows:
  Ttype[8] = flag-update enable
  Ttype[6:5] = branch condition: 00 none, 01 taken if flag_z, 10 taken if !flag_z, 11 taken if flag_cy
  all other Ttype bits ignored

Function
REQ-005 SHALL implement four states: IDLE, EXEC, MEM, RETIRE.
REQ-006 IDLE behaviour:
  - mir_ready=1
  - mir_valid=1 latches mir into an internal hold register and moves to EXEC next cycle
  - mir is not sampled in any other state
REQ-007 EXEC behaviour (exactly one cycle):
  - drive alu_op, sh_op, kmx, a_sel, b_sel, c_sel from the held word
  - if Ttype[8]=1, capture alu_z into flag_z and alu_cy into flag_cy at the end of the cycle
REQ-008 EXEC write strobe: c_we=1 only if Cbus!=0 and MR=0; when MR=1 the write is deferred to the mem_ack cycle in MEM.
REQ-009 EXEC next state: MEM if MR or MW is set, otherwise RETIRE.
REQ-010 MR=1 and MW=1 together SHALL be treated as a read only (MW ignored).
REQ-011 MEM behaviour:
  - hold mem_rd (or mem_wr) and all bus selects steady until mem_ack=1
  - on the mem_ack cycle: drop the request the next cycle, pulse c_we for one cycle if MR=1 and Cbus!=0, then go to RETIRE
REQ-012 MEM timeout:
  - a 4-bit wait counter clears on MEM entry and increments each cycle without mem_ack
  - on reaching 15 without mem_ack: drop the request, set mem_err, go to RETIRE with no c_we
REQ-013 RETIRE behaviour (exactly one cycle):
  - done=1
  - pc loads br_addr if the branch condition holds, otherwise pc increments by 1 modulo 4096 (0xFFF wraps to 0x000)
  - the branch uses flag values including any update made in this microinstruction's EXEC
REQ-014 RETIRE next state: IDLE. mir_ready is 0 in EXEC, MEM and RETIRE.
REQ-015 Latency:
  - non-memory microinstruction: mir_valid accepted at cycle N, EXEC at N+1, done at N+2, next accept at N+3
  - memory access: add (cycles until mem_ack inclusive) to the above
REQ-016 Outside EXEC/MEM: alu_op, sh_op, kmx, a_sel, b_sel, c_sel, c_we, mem_rd, mem_wr all SHALL be 0.
REQ-017 mem_ack outside MEM SHALL be ignored.
REQ-018 mem_err SHALL remain set until reset.

Reset
REQ-019 rst_n=0 at a rising clk edge SHALL force:
  - state IDLE, pc=0, flag_z=0, flag_cy=0, mem_err=0, done=0, wait counter=0
  - all control outputs 0
REQ-020 Reset asserted mid-operation (EXEC/MEM/RETIRE) SHALL abort it:
  - no done pulse
  - no pc update
  - request deasserted from the next cycle
REQ-021 mir_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after release.

Verification
REQ-022 Bench: MOK-style word (ALU=0, Cbus=0x11, Ttype=0) with mir_valid for one cycle -> next cycle c_we=1 and c_sel=0x11; following cycle done=1 and pc 0x000->0x001.
REQ-023 Bench: MR=1, Cbus=0x05, mem_ack at the 3rd MEM cycle -> mem_rd high for exactly 3 cycles, c_we pulses on the ack cycle, then done, pc+1.
REQ-024 Bench: Ttype[8]=1, alu_z=1 in EXEC, Ttype[6:5]=01, br_addr=0x3A5 -> flag_z=1 and pc=0x3A5 after done; repeat with alu_z=0 -> pc increments.
REQ-025 Bench: MW=1 and mem_ack never asserted -> mem_wr held 15 cycles, mem_err=1, done pulses, no c_we; mem_err stays 1 until rst_n=0.
REQ-026 Bench: pc=0xFFF, non-branch word -> pc=0x000 after done.
REQ-027 Bench: rst_n=0 during MEM -> next cycle mem_rd=0, state IDLE, no done pulse, pc=0.
